// File: rtl/max_pool_2x2_pkg.sv
// Shared CNN types and dimensions for the pooling stage and dense_layer1.
// Keeping the widths here means both layers agree on pixel size and map geometry.
package cnn_pkg;

    localparam int DATA_W   = 16;
    localparam int IMG_DIM  = 28;
    localparam int POOL_DIM = IMG_DIM / 2;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/max_pool_2x2_if.sv
// Image-in / pooled-map-out bundle between the pooling stage and its controller.
interface max_pool_2x2_if #(
    parameter int IMG_DIM = cnn_pkg::IMG_DIM,
    parameter int DATA_W  = cnn_pkg::DATA_W
);
    localparam int POOL_DIM = IMG_DIM / 2;

    logic                     enable;
    logic signed [DATA_W-1:0] img  [0:IMG_DIM*IMG_DIM-1];
    logic signed [DATA_W-1:0] pool [0:POOL_DIM*POOL_DIM-1];
    logic                     pool_done;

    modport master (output enable, output img, input pool, input pool_done);
    modport slave  (input enable, input img, output pool, output pool_done);
endinterface

// File: rtl/max_pool_2x2_max4_signed.sv
// Combinational signed maximum of four pixels, built as a two-level compare tree.
module max4_signed #(
    parameter int DATA_W = cnn_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    input  logic signed [DATA_W-1:0] d,
    output logic signed [DATA_W-1:0] m
);
    logic signed [DATA_W-1:0] ab_s;
    logic signed [DATA_W-1:0] cd_s;

    assign ab_s = (a > b) ? a : b;
    assign cd_s = (c > d) ? c : d;
    assign m    = (ab_s > cd_s) ? ab_s : cd_s;
endmodule

// File: rtl/max_pool_2x2.sv
// Stride-2 2x2 max pooling: one window per clock, row-major, optional ReLU clamp.
module max_pool_2x2
    import cnn_pkg::pool_state_t, cnn_pkg::IDLE, cnn_pkg::RUN, cnn_pkg::DONE;
#(
    parameter int IMG_DIM = cnn_pkg::IMG_DIM,
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter bit RELU_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    max_pool_2x2_if.slave  bus
);
    localparam int POOL_DIM = IMG_DIM / 2;
    localparam int NPOOL    = POOL_DIM * POOL_DIM;
    localparam int CW       = (POOL_DIM > 1) ? $clog2(POOL_DIM) : 1;
    localparam int AW       = $clog2(IMG_DIM * IMG_DIM);
    localparam int PW       = (NPOOL > 1) ? $clog2(NPOOL) : 1;

    pool_state_t              state_r;
    pool_state_t              state_s;
    logic [CW-1:0]            r_r;
    logic [CW-1:0]            c_r;
    logic                     start_s;
    logic                     wr_en_s;
    logic                     last_s;
    logic                     done_nxt_s;
    logic                     pool_done_r;
    logic [AW-1:0]            base_s;
    logic [PW-1:0]            pidx_s;
    logic signed [DATA_W-1:0] max_s;
    logic signed [DATA_W-1:0] relu_s;
    logic signed [DATA_W-1:0] pool_r [0:NPOOL-1];

    // Top-left pixel of window (r, c) and the matching output slot.
    assign base_s = AW'(r_r) * AW'(2 * IMG_DIM) + AW'(2) * AW'(c_r);
    assign pidx_s = PW'(r_r) * PW'(POOL_DIM) + PW'(c_r);
    assign last_s = (r_r == CW'(POOL_DIM - 1)) && (c_r == CW'(POOL_DIM - 1));

    max4_signed #(.DATA_W(DATA_W)) u_max4 (
        .a (bus.img[base_s]),
        .b (bus.img[base_s + AW'(1)]),
        .c (bus.img[base_s + AW'(IMG_DIM)]),
        .d (bus.img[base_s + AW'(IMG_DIM + 1)]),
        .m (max_s)
    );

    assign relu_s = (RELU_EN && max_s[DATA_W-1]) ? {DATA_W{1'b0}} : max_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath strobes; dropping enable in RUN aborts without a write.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        wr_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.enable) begin
                    state_s = RUN;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_s = IDLE;
                end else begin
                    wr_en_s = 1'b1;
                    state_s = last_s ? DONE : RUN;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        done_nxt_s = (state_s == DONE);
    end

    // Window counters, output map and completion flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r         <= {CW{1'b0}};
            c_r         <= {CW{1'b0}};
            pool_done_r <= 1'b0;
            for (int i = 0; i < NPOOL; i++) begin
                pool_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            pool_done_r <= done_nxt_s;
            if (start_s) begin
                r_r <= {CW{1'b0}};
                c_r <= {CW{1'b0}};
            end else if (wr_en_s) begin
                pool_r[pidx_s] <= relu_s;
                if (c_r == CW'(POOL_DIM - 1)) begin
                    c_r <= {CW{1'b0}};
                    r_r <= r_r + CW'(1);
                end else begin
                    c_r <= c_r + CW'(1);
                end
            end else begin
                r_r <= r_r;
                c_r <= c_r;
            end
        end
    end

    assign bus.pool      = pool_r;
    assign bus.pool_done = pool_done_r;
endmodule

// File: tb/tb_max_pool_2x2.sv
// Randomized self-checking bench for max_pool_2x2 (ReLU on and off instances).
module tb_max_pool_2x2;
    localparam int ID = 28;
    localparam int PD = 14;
    localparam int NP = PD * PD;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic signed [15:0] img [0:ID*ID-1];
    logic signed [15:0] exp_r [0:NP-1];
    logic signed [15:0] exp_n [0:NP-1];
    int n_cmp = 0;
    int n_err = 0;

    max_pool_2x2_if #(.IMG_DIM(ID), .DATA_W(16)) ifr ();
    max_pool_2x2_if #(.IMG_DIM(ID), .DATA_W(16)) ifn ();

    assign ifr.enable = enable;
    assign ifr.img    = img;
    assign ifn.enable = enable;
    assign ifn.img    = img;

    max_pool_2x2 #(.IMG_DIM(ID), .DATA_W(16), .RELU_EN(1'b1)) dut_r (.clk(clk), .reset(reset), .bus(ifr));
    max_pool_2x2 #(.IMG_DIM(ID), .DATA_W(16), .RELU_EN(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(ifn));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each pooled value is the largest of its 2x2 window, clamped for ReLU.
    task automatic model_update(input int upto);
        for (int k = 0; k < upto; k++) begin
            int r = k / PD;
            int c = k % PD;
            int m = -100000;
            for (int dy = 0; dy < 2; dy++)
                for (int dx = 0; dx < 2; dx++)
                    if (int'(img[(2*r+dy)*ID + 2*c+dx]) > m) m = int'(img[(2*r+dy)*ID + 2*c+dx]);
            exp_n[k] = 16'(m);
            exp_r[k] = (m < 0) ? 16'sd0 : 16'(m);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NP; k++) begin
            exp_r[k] = 16'sd0;
            exp_n[k] = 16'sd0;
        end
    endtask

    task automatic check_pool(input string nm);
        for (int k = 0; k < NP; k++) begin
            n_cmp++;
            if (ifr.pool[k] !== exp_r[k]) begin
                n_err++;
                $display("FAIL %s relu pool[%0d] got %0d exp %0d", nm, k, ifr.pool[k], exp_r[k]);
            end
            n_cmp++;
            if (ifn.pool[k] !== exp_n[k]) begin
                n_err++;
                $display("FAIL %s norelu pool[%0d] got %0d exp %0d", nm, k, ifn.pool[k], exp_n[k]);
            end
        end
    endtask

    task automatic check_done(input string nm, input logic expv);
        n_cmp++;
        if (ifr.pool_done !== expv || ifn.pool_done !== expv) begin
            n_err++;
            $display("FAIL %s pool_done got %b/%b exp %b", nm, ifr.pool_done, ifn.pool_done, expv);
        end
    endtask

    // Full run from IDLE: latency, contents, hold in DONE, release on enable low.
    task automatic run_full(input string nm);
        int n;
        enable = 1'b1;
        tick();
        n = 0;
        while (ifr.pool_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != NP) begin
            n_err++;
            $display("FAIL %s done_latency got %0d exp %0d", nm, n, NP);
        end
        check_done(nm, 1'b1);
        model_update(NP);
        check_pool(nm);
        repeat (3) tick();
        check_done({nm, "_hold"}, 1'b1);
        enable = 1'b0;
        tick();
        check_done({nm, "_release"}, 1'b0);
        check_pool({nm, "_held"});
    endtask

    task automatic rand_img();
        for (int i = 0; i < ID*ID; i++) img[i] = 16'($urandom);
    endtask

    task automatic zero_img();
        for (int i = 0; i < ID*ID; i++) img[i] = 16'sd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        rand_img();
        repeat (3) tick();
        model_clear();
        check_pool("reset");
        check_done("reset", 1'b0);
        reset = 1'b0;
        repeat (10) tick();
        check_pool("post_reset_idle");
        check_done("post_reset_idle", 1'b0);
    endtask

    task automatic test_digit();
        zero_img();
        for (int y = 4; y < 24; y++)
            for (int x = 10; x < 18; x++)
                img[y*ID + x] = 16'($urandom_range(0, 57));
        img[4*ID + 10] = 16'sd58;
        run_full("digit");
        n_cmp++;
        if (ifr.pool[33] !== 16'sd58 || ifr.pool[0] !== 16'sd0) begin
            n_err++;
            $display("FAIL digit_golden pool[33]=%0d pool[0]=%0d exp 58/0", ifr.pool[33], ifr.pool[0]);
        end
    endtask

    task automatic test_signed_relu();
        zero_img();
        img[0] = -16'sd5; img[1] = -16'sd3; img[ID] = -16'sd100; img[ID+1] = -16'sd7;
        run_full("neg_window");
        n_cmp++;
        if (ifr.pool[0] !== 16'sd0 || ifn.pool[0] !== -16'sd3) begin
            n_err++;
            $display("FAIL neg_window relu=%0d norelu=%0d exp 0/-3", ifr.pool[0], ifn.pool[0]);
        end
        img[0] = -16'sd32768; img[1] = 16'sd32767; img[ID] = 16'sd0; img[ID+1] = 16'sd1;
        run_full("extreme_window");
        n_cmp++;
        if (ifr.pool[0] !== 16'sd32767 || ifn.pool[0] !== 16'sd32767) begin
            n_err++;
            $display("FAIL extreme_window relu=%0d norelu=%0d exp 32767", ifr.pool[0], ifn.pool[0]);
        end
    endtask

    task automatic test_ordering();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        zero_img();
        for (int r = 0; r < PD; r++)
            for (int c = 0; c < PD; c++)
                img[(2*r)*ID + 2*c] = 16'(r*PD + c);
        enable = 1'b1;
        tick();
        repeat (13) tick();
        n_cmp++;
        if (ifr.pool[12] !== 16'sd12 || ifr.pool[13] !== 16'sd0) begin
            n_err++;
            $display("FAIL order_e13 pool[12]=%0d pool[13]=%0d exp 12/0", ifr.pool[12], ifr.pool[13]);
        end
        tick();
        n_cmp++;
        if (ifr.pool[13] !== 16'sd13 || ifr.pool[14] !== 16'sd0) begin
            n_err++;
            $display("FAIL order_e14 pool[13]=%0d pool[14]=%0d exp 13/0", ifr.pool[13], ifr.pool[14]);
        end
        tick();
        n_cmp++;
        if (ifr.pool[14] !== 16'sd14) begin
            n_err++;
            $display("FAIL order_e15 pool[14]=%0d exp 14", ifr.pool[14]);
        end
        repeat (200) tick();
        check_done("order_done", 1'b1);
        for (int k = 0; k < NP; k++) begin
            n_cmp++;
            if (ifn.pool[k] !== 16'(k)) begin
                n_err++;
                $display("FAIL order_value pool[%0d] got %0d exp %0d", k, ifn.pool[k], k);
            end
        end
        enable = 1'b0;
        tick();
        model_update(NP);
    endtask

    task automatic test_abort();
        rand_img();
        run_full("abort_prior");
        rand_img();
        enable = 1'b1;
        tick();
        repeat (49) tick();
        enable = 1'b0;
        tick();
        model_update(49);
        for (int i = 0; i < 6; i++) begin
            check_done("abort_no_done", 1'b0);
            tick();
        end
        check_pool("abort_partial");
        run_full("abort_rerun");
    endtask

    task automatic test_midrun_reset();
        rand_img();
        enable = 1'b1;
        tick();
        repeat (100) tick();
        #1 reset = 1'b1;
        #1;
        model_clear();
        check_pool("async_reset");
        check_done("async_reset", 1'b0);
        enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_full("after_reset");
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        zero_img();
        test_reset();
        test_digit();
        test_signed_relu();
        test_ordering();
        rand_img();
        run_full("random");
        test_abort();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
